fft_frame_scheduler: RTL and testbench

//  Moves one complete FFT frame per video frame from one of two FFT output FIFOs into a double-buffered display RAM.

---
 rtl/fft_disp_pkg.sv | 20 ++
 rtl/fft_frame_scheduler_if.sv | 39 +++
 rtl/fft_rr_arb2.sv | 21 ++
 rtl/fft_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_disp_pkg.sv
// Shared constants, FSM state type and helpers for the FFT display scheduler.
package fft_disp_pkg;

    localparam int unsigned N_POINTS = 512;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        FLUSH,
        READY
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// FIFO read side and display-RAM write side of the FFT frame scheduler.
interface fft_frame_scheduler_if;
    import fft_disp_pkg::*;

    logic              fifo_empty1;
    logic              fifo_rd_req1;
    logic [DATA_W-1:0] fifo_data1;
    logic              fifo_empty2;
    logic              fifo_rd_req2;
    logic [DATA_W-1:0] fifo_data2;
    logic              ram_wr_en;
    logic [ADDR_W:0]   ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;

    modport master (
        input  fifo_empty1,
        input  fifo_data1,
        input  fifo_empty2,
        input  fifo_data2,
        output fifo_rd_req1,
        output fifo_rd_req2,
        output ram_wr_en,
        output ram_wr_addr,
        output ram_wr_data
    );

    modport slave (
        output fifo_empty1,
        output fifo_data1,
        output fifo_empty2,
        output fifo_data2,
        input  fifo_rd_req1,
        input  fifo_rd_req2,
        input  ram_wr_en,
        input  ram_wr_addr,
        input  ram_wr_data
    );

endinterface

// File: rtl/fft_rr_arb2.sv
// Two-way round-robin picker: prefers the enabled channel that was not served last.
module fft_rr_arb2
    import fft_disp_pkg::*;
(
    input  logic [1:0] i_ch_en,
    input  logic       i_rr_last,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_ch_en;
        o_grant = 1'b0;
        if (i_ch_en[~i_rr_last]) begin
            o_grant = ~i_rr_last;
        end else if (i_ch_en[i_rr_last]) begin
            o_grant = i_rr_last;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Copies one FFT frame per video frame from two result FIFOs into the hidden bank
// of a double-buffered display RAM; banks swap only on a vsync rising edge.
module fft_frame_scheduler
    import fft_disp_pkg::*;
(
    input  logic                  pix_clk,
    input  logic                  rstn,
    input  logic                  i_vs_in,
    input  logic [1:0]            i_ch_en,
    fft_frame_scheduler_if.master bus,
    output logic                  o_disp_bank,
    output logic                  o_disp_ch,
    output logic                  o_frame_swap,
    output logic [7:0]            o_miss_cnt
);

    localparam int unsigned     PT_W    = ADDR_W + 1;
    localparam logic [PT_W-1:0] N_PTS   = PT_W'(N_POINTS);
    localparam logic [PT_W-1:0] LAST_PT = PT_W'(N_POINTS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_vs_d;
    logic              r_cur_ch;
    logic              r_rr_last;
    logic [PT_W-1:0]   r_pt_cnt;
    logic              r_wr_en;
    logic [ADDR_W:0]   r_wr_addr;
    logic              r_disp_bank;
    logic              r_disp_ch;
    logic              r_frame_swap;
    logic [7:0]        r_miss_cnt;

    logic              w_vs_rise;
    logic              w_grant;
    logic              w_grant_vld;
    logic              w_cur_en;
    logic              w_cur_empty;
    logic [DATA_W-1:0] w_cur_data;
    logic              w_rd_req;
    logic              w_swap;
    logic              w_miss;

    fft_rr_arb2 u_arb (
        .i_ch_en   (i_ch_en),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant),
        .o_valid   (w_grant_vld)
    );

    assign w_vs_rise   = i_vs_in & ~r_vs_d;
    assign w_cur_en    = r_cur_ch ? i_ch_en[1] : i_ch_en[0];
    assign w_cur_empty = r_cur_ch ? bus.fifo_empty2 : bus.fifo_empty1;
    assign w_cur_data  = r_cur_ch ? bus.fifo_data2 : bus.fifo_data1;
    // Any boundary that does not produce a swap is a miss, including one that lands on FLUSH->READY.
    assign w_miss      = w_vs_rise & ~w_swap;

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_req    = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_ch_en) begin
                    w_state_nxt = ARB;
                end
            end
            ARB: begin
                w_state_nxt = w_grant_vld ? LOAD : IDLE;
            end
            LOAD: begin
                if (!w_cur_en) begin
                    w_state_nxt = ARB;
                end else begin
                    w_rd_req = ~w_cur_empty & (r_pt_cnt < N_PTS);
                    if (w_rd_req && (r_pt_cnt == LAST_PT)) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_state_nxt = w_cur_en ? READY : ARB;
            end
            READY: begin
                if (!w_cur_en) begin
                    w_state_nxt = ARB;
                end else if (w_vs_rise) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ARB;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_d       <= 1'b0;
            r_cur_ch     <= 1'b0;
            r_rr_last    <= 1'b1;
            r_pt_cnt     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_disp_bank  <= 1'b0;
            r_disp_ch    <= 1'b0;
            r_frame_swap <= 1'b0;
            r_miss_cnt   <= '0;
        end else begin
            r_vs_d       <= i_vs_in;
            r_wr_en      <= w_rd_req;
            r_frame_swap <= w_swap;
            if ((r_state == ARB) && w_grant_vld) begin
                r_cur_ch <= w_grant;
                r_pt_cnt <= '0;
            end
            // Address is captured with the request so it lines up with the FIFO data one cycle later.
            if (w_rd_req) begin
                r_wr_addr <= {~r_disp_bank, r_pt_cnt[ADDR_W-1:0]};
                r_pt_cnt  <= r_pt_cnt + 1'b1;
            end
            if (w_swap) begin
                r_disp_bank <= ~r_disp_bank;
                r_disp_ch   <= r_cur_ch;
                r_rr_last   <= r_cur_ch;
            end
            if (w_miss) begin
                r_miss_cnt <= sat_inc8(r_miss_cnt);
            end
        end
    end

    assign bus.fifo_rd_req1 = w_rd_req & ~r_cur_ch;
    assign bus.fifo_rd_req2 = w_rd_req & r_cur_ch;
    assign bus.ram_wr_en    = r_wr_en;
    assign bus.ram_wr_addr  = r_wr_addr;
    assign bus.ram_wr_data  = r_wr_en ? w_cur_data : '0;

    assign o_disp_bank  = r_disp_bank;
    assign o_disp_ch    = r_disp_ch;
    assign o_frame_swap = r_frame_swap;
    assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: frame table plus hand-written corner sequences.
module tb_fft_frame_scheduler;
    import fft_disp_pkg::*;

    typedef struct {
        logic [1:0] ch_en;
        logic       exp_ch;
        logic       exp_bank;
        logic [7:0] exp_miss;
    } frame_vec_t;

    logic       pix_clk = 1'b0;
    logic       rstn;
    logic       vs_in;
    logic [1:0] ch_en;
    logic       disp_bank;
    logic       disp_ch;
    logic       frame_swap;
    logic [7:0] miss_cnt;

    logic       fifo_clr;
    logic       gap1;
    logic       gap2;
    logic [8:0] cnt1;
    logic [8:0] cnt2;

    int   n_pass;
    int   n_total;
    int   wr_cnt;
    int   swap_cnt;
    logic ld_ch;
    logic exp_disp_bank;

    fft_frame_scheduler_if bus ();

    fft_frame_scheduler dut (
        .pix_clk      (pix_clk),
        .rstn         (rstn),
        .i_vs_in      (vs_in),
        .i_ch_en      (ch_en),
        .bus          (bus),
        .o_disp_bank  (disp_bank),
        .o_disp_ch    (disp_ch),
        .o_frame_swap (frame_swap),
        .o_miss_cnt   (miss_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    // FIFO model: word = {channel, 22'b0, running index mod 512}, returned one cycle after the request.
    assign bus.fifo_empty1 = gap1;
    assign bus.fifo_empty2 = gap2;

    always @(posedge pix_clk) begin
        if (fifo_clr) begin
            cnt1           <= '0;
            cnt2           <= '0;
            bus.fifo_data1 <= '0;
            bus.fifo_data2 <= '0;
        end else begin
            if (bus.fifo_rd_req1) begin
                bus.fifo_data1 <= {1'b0, 22'd0, cnt1};
                cnt1           <= cnt1 + 9'd1;
            end
            if (bus.fifo_rd_req2) begin
                bus.fifo_data2 <= {1'b1, 22'd0, cnt2};
                cnt2           <= cnt2 + 9'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] exp_addr;
        @(negedge pix_clk);
        if (bus.fifo_rd_req1 | bus.fifo_rd_req2) begin
            chk("rd_sel", {62'd0, bus.fifo_rd_req2, bus.fifo_rd_req1}, ld_ch ? 64'd2 : 64'd1);
            chk("rd_on_empty", 64'((bus.fifo_rd_req1 & bus.fifo_empty1) | (bus.fifo_rd_req2 & bus.fifo_empty2)), 64'd0);
        end
        if (bus.ram_wr_en) begin
            exp_addr = {~exp_disp_bank, wr_cnt[8:0]};
            chk("wr_addr", 64'(bus.ram_wr_addr), 64'(exp_addr));
            chk("wr_data", 64'(bus.ram_wr_data), {32'd0, ld_ch, 22'd0, wr_cnt[8:0]});
            wr_cnt++;
        end
        if (frame_swap) begin
            swap_cnt++;
        end
    endtask

    task automatic wait_writes(input int n, input string name);
        int budget = 4000;
        while ((wr_cnt < n) && (budget > 0)) begin
            tick();
            budget--;
        end
        chk(name, 64'(wr_cnt), 64'(n));
    endtask

    task automatic do_reset(input logic [1:0] en_during);
        rstn     = 1'b0;
        vs_in    = 1'b0;
        ch_en    = en_during;
        gap1     = 1'b0;
        gap2     = 1'b0;
        fifo_clr = 1'b1;
        tick();
        tick();
        chk("reset_outs", 64'({bus.fifo_rd_req1, bus.fifo_rd_req2, bus.ram_wr_en, bus.ram_wr_addr,
                               bus.ram_wr_data, disp_bank, disp_ch, frame_swap, miss_cnt}), 64'd0);
        fifo_clr      = 1'b0;
        rstn          = 1'b1;
        exp_disp_bank = 1'b0;
        wr_cnt        = 0;
        swap_cnt      = 0;
        ld_ch         = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1000000 time units");
        $fatal(1);
    end

    initial begin
        frame_vec_t vecs[5];
        logic       sw;
        int         w;

        n_pass        = 0;
        n_total       = 0;
        wr_cnt        = 0;
        swap_cnt      = 0;
        ld_ch         = 1'b0;
        exp_disp_bank = 1'b0;

        // Frame 0 is ch1 alone; then both enabled so service alternates ch2, ch1, ch2, ch1.
        vecs[0] = '{2'b01, 1'b0, 1'b1, 8'd0};
        vecs[1] = '{2'b11, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{2'b11, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 8'd0};
        vecs[4] = '{2'b11, 1'b0, 1'b1, 8'd0};

        do_reset(2'b00);
        ch_en = vecs[0].ch_en;
        ld_ch = vecs[0].exp_ch;
        for (int unsigned i = 0; i < 5; i++) begin
            wait_writes(512, "frame_writes");
            tick();
            tick();
            tick();
            chk("no_early_swap", 64'(swap_cnt), 64'(i));
            vs_in = 1'b1;
            tick();
            sw    = frame_swap;
            vs_in = 1'b0;
            chk("frame_swap", 64'(sw), 64'd1);
            chk("disp_ch", 64'(disp_ch), 64'(vecs[i].exp_ch));
            chk("disp_bank", 64'(disp_bank), 64'(vecs[i].exp_bank));
            chk("miss_cnt", 64'(miss_cnt), 64'(vecs[i].exp_miss));
            exp_disp_bank = vecs[i].exp_bank;
            wr_cnt        = 0;
            if (i < 4) begin
                ch_en = vecs[i+1].ch_en;
                ld_ch = vecs[i+1].exp_ch;
            end
        end

        // FIFO1 runs dry for 20 cycles just before point 100.
        do_reset(2'b00);
        ch_en = 2'b01;
        wait_writes(100, "t3_pre_gap");
        gap1 = 1'b1;
        w    = wr_cnt;
        repeat (20) tick();
        chk("t3_gap_writes", 64'(wr_cnt), 64'(w));
        chk("t3_gap_point", 64'(w), 64'd100);
        gap1 = 1'b0;
        wait_writes(512, "t3_total");
        repeat (5) tick();
        chk("t3_no_extra", 64'(wr_cnt), 64'd512);

        // Boundary mid-load, then one coinciding with FLUSH->READY, then a real swap.
        do_reset(2'b00);
        ch_en = 2'b01;
        wait_writes(300, "t4_pre_vs");
        vs_in = 1'b1;
        tick();
        sw    = frame_swap;
        vs_in = 1'b0;
        chk("t4_mid_no_swap", 64'(sw), 64'd0);
        chk("t4_miss1", 64'(miss_cnt), 64'd1);
        wait_writes(512, "t4_load_done");
        vs_in = 1'b1;
        tick();
        sw    = frame_swap;
        vs_in = 1'b0;
        chk("t4_flush_no_swap", 64'(sw), 64'd0);
        chk("t4_miss2", 64'(miss_cnt), 64'd2);
        tick();
        tick();
        chk("t4_swap_count", 64'(swap_cnt), 64'd0);
        vs_in = 1'b1;
        tick();
        sw    = frame_swap;
        vs_in = 1'b0;
        chk("t4_swap", 64'(sw), 64'd1);
        chk("t4_disp_bank", 64'(disp_bank), 64'd1);
        chk("t4_disp_ch", 64'(disp_ch), 64'd0);
        chk("t4_miss_hold", 64'(miss_cnt), 64'd2);
        exp_disp_bank = 1'b1;
        wr_cnt        = 0;
        ld_ch         = 1'b0;

        // Channel disabled at point 200 of the next frame: abort, display untouched.
        wait_writes(200, "t5_pre_abort");
        ch_en = 2'b00;
        tick();
        tick();
        w = wr_cnt;
        repeat (10) tick();
        chk("t5_no_writes", 64'(wr_cnt), 64'(w));
        chk("t5_abort_prompt", 64'(w <= 201), 64'd1);
        chk("t5_disp_bank", 64'(disp_bank), 64'd1);
        chk("t5_disp_ch", 64'(disp_ch), 64'd0);
        chk("t5_no_swap", 64'(swap_cnt), 64'd1);

        // Restart, then reset at point 250; the reload must start from bank 1 address 0.
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        ch_en    = 2'b01;
        wr_cnt   = 0;
        wait_writes(250, "t6_pre_reset");
        do_reset(2'b01);
        wait_writes(1, "t6_first_write");
        chk("t6_first_addr", 64'(bus.ram_wr_addr), 64'h200);
        wait_writes(512, "t6_reload");
        tick();
        tick();
        tick();
        vs_in = 1'b1;
        tick();
        sw    = frame_swap;
        vs_in = 1'b0;
        chk("t6_swap", 64'(sw), 64'd1);
        chk("t6_disp_bank", 64'(disp_bank), 64'd1);
        chk("t6_disp_ch", 64'(disp_ch), 64'd0);
        chk("t6_miss", 64'(miss_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
